// File: rtl/accumulator_ctrl.sv
// accumulator_ctrl: burst sequencer driving an external 8-bit signed accumulator
//   i_clk, ni_rst          : clock, async active-low reset
//   i_start, i_len         : burst request and operand count (IDLE only)
//   i_abort                : abort, honored in CLR and LOAD
//   i_vld, i_data, o_rdy   : operand stream (transfer = i_vld & o_rdy)
//   o_a_data, o_a_clr, o_s_clr, o_a_ld, o_s_ld : accumulator controls
//   i_carry, i_ovf         : accumulator flags, valid while o_s_ld is high
//   o_busy, o_cnt, o_done  : status, operands remaining, completion pulse
//   o_carry_st, o_ovf_st, o_abort_st : sticky burst status
module accumulator_ctrl #(
  parameter int unsigned CNT_W       = 4,
  parameter bit          STOP_ON_OVF = 1'b0
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_abort,
  input  logic             i_vld,
  input  logic [7:0]       i_data,
  output logic             o_rdy,
  output logic [7:0]       o_a_data,
  output logic             o_a_clr,
  output logic             o_s_clr,
  output logic             o_a_ld,
  output logic             o_s_ld,
  input  logic             i_carry,
  input  logic             i_ovf,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_done,
  output logic             o_carry_st,
  output logic             o_ovf_st,
  output logic             o_abort_st
);
  typedef enum logic [2:0] {IDLE, CLR, LOAD, ADD, DONE} state_t;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry_st;
  logic             r_ovf_st;
  logic             r_abort_st;
  logic [CNT_W-1:0] w_cnt_dec;
  assign w_cnt_dec = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_carry_st <= 1'b0;
      r_ovf_st   <= 1'b0;
      r_abort_st <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_cnt      <= i_len;
          r_carry_st <= 1'b0;
          r_ovf_st   <= 1'b0;
          r_abort_st <= 1'b0;
          r_state    <= CLR;
        end
        CLR: if (i_abort) begin
          r_abort_st <= 1'b1;
          r_state    <= DONE;
        end else begin
          r_state <= (r_cnt == '0) ? DONE : LOAD;
        end
        LOAD: if (i_abort) begin
          r_abort_st <= 1'b1;
          r_state    <= DONE;
        end else if (i_vld) begin
          r_state <= ADD;
        end
        ADD: begin
          r_carry_st <= r_carry_st | i_carry;
          r_ovf_st   <= r_ovf_st | i_ovf;
          r_cnt      <= w_cnt_dec;
          r_state    <= (w_cnt_dec == '0 || (STOP_ON_OVF && i_ovf)) ? DONE : LOAD;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // abort wins over a pending transfer in LOAD
  assign o_rdy      = (r_state == LOAD) & ~i_abort;
  assign o_a_ld     = o_rdy & i_vld;
  assign o_a_data   = i_data;
  assign o_a_clr    = r_state == CLR;
  assign o_s_clr    = r_state == CLR;
  assign o_s_ld     = r_state == ADD;
  assign o_busy     = r_state != IDLE;
  assign o_done     = r_state == DONE;
  assign o_cnt      = r_cnt;
  assign o_carry_st = r_carry_st;
  assign o_ovf_st   = r_ovf_st;
  assign o_abort_st = r_abort_st;
endmodule

// File: tb/tb_accumulator_ctrl.sv
// tb_accumulator_ctrl: directed vectors for accumulator_ctrl (normal and stop-on-overflow builds)
module tb_accumulator_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] len = '0;
  logic abort = 1'b0;
  logic vld = 1'b0;
  logic [7:0] data = '0;
  logic [1:0] rdy, a_clr, s_clr, a_ld, s_ld, carry, ovf, busy, done, carry_st, ovf_st, abort_st;
  logic [1:0][7:0] a_data;
  logic [1:0][3:0] cnt;
  logic [1:0][7:0] a_r, s_r;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  accumulator_ctrl #(.CNT_W(4), .STOP_ON_OVF(1'b0)) dut0 (
    .i_clk(clk), .ni_rst(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .i_vld(vld), .i_data(data), .o_rdy(rdy[0]), .o_a_data(a_data[0]),
    .o_a_clr(a_clr[0]), .o_s_clr(s_clr[0]), .o_a_ld(a_ld[0]), .o_s_ld(s_ld[0]),
    .i_carry(carry[0]), .i_ovf(ovf[0]), .o_busy(busy[0]), .o_cnt(cnt[0]),
    .o_done(done[0]), .o_carry_st(carry_st[0]), .o_ovf_st(ovf_st[0]), .o_abort_st(abort_st[0])
  );
  accumulator_ctrl #(.CNT_W(4), .STOP_ON_OVF(1'b1)) dut1 (
    .i_clk(clk), .ni_rst(rst_n), .i_start(start), .i_len(len), .i_abort(abort),
    .i_vld(vld), .i_data(data), .o_rdy(rdy[1]), .o_a_data(a_data[1]),
    .o_a_clr(a_clr[1]), .o_s_clr(s_clr[1]), .o_a_ld(a_ld[1]), .o_s_ld(s_ld[1]),
    .i_carry(carry[1]), .i_ovf(ovf[1]), .o_busy(busy[1]), .o_cnt(cnt[1]),
    .o_done(done[1]), .o_carry_st(carry_st[1]), .o_ovf_st(ovf_st[1]), .o_abort_st(abort_st[1])
  );
  // external accumulator: one per controller
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (a_clr[i]) a_r[i] <= '0;
      else if (a_ld[i]) a_r[i] <= a_data[i];
      if (s_clr[i]) s_r[i] <= '0;
      else if (s_ld[i]) s_r[i] <= s_r[i] + a_r[i];
    end
  end
  always_comb begin
    carry = '0;
    ovf = '0;
    for (int i = 0; i < 2; i++) begin
      logic [8:0] sum;
      sum = {1'b0, s_r[i]} + {1'b0, a_r[i]};
      carry[i] = sum[8];
      ovf[i] = (s_r[i][7] == a_r[i][7]) && (sum[7] != s_r[i][7]);
    end
  end
  typedef struct {
    logic [3:0] len;
    logic [15:0][7:0] ops;
    logic [63:0] low, abt, stm;
    int done_c, s, c_st, o_st, a_st, cnt, ald, sld, done1, s1, o_st1, cnt1, rdy1;
  } vec_t;
  function automatic logic [15:0][7:0] ops(input logic [7:0] a, b, c, d, f);
    logic [15:0][7:0] r;
    for (int i = 0; i < 16; i++) r[i] = f;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic chk_zero(input string n, input int i);
    chk(n, int'({rdy[i], busy[i], done[i], a_clr[i], s_clr[i], a_ld[i], s_ld[i],
                 carry_st[i], ovf_st[i], abort_st[i], cnt[i]}), 0);
  endtask
  task automatic run_vec(input string nm, input vec_t v);
    int k = 0, idx = 0, dc = 0, dc1 = 0, nald = 0, nsld = 0, lr1 = 0;
    start = 1'b1; len = v.len; vld = 1'b0; abort = 1'b0; data = v.ops[0];
    while (dc == 0 && k < 80) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      start = v.stm[k]; vld = !v.low[k]; abort = v.abt[k]; data = v.ops[idx];
      #1;
      if (a_ld[0]) nald++;
      if (s_ld[0]) nsld++;
      if (rdy[1]) lr1 = k;
      if (vld && rdy[0] && idx < 15) idx++;
      if (done[1] && dc1 == 0) dc1 = k;
      if (done[0]) dc = k;
    end
    start = 1'b0; vld = 1'b0; abort = 1'b0;
    chk({nm, " done_cycle"}, dc, v.done_c);
    chk({nm, " S"}, int'(s_r[0]), v.s);
    chk({nm, " carry_st"}, int'(carry_st[0]), v.c_st);
    chk({nm, " ovf_st"}, int'(ovf_st[0]), v.o_st);
    chk({nm, " abort_st"}, int'(abort_st[0]), v.a_st);
    chk({nm, " cnt"}, int'(cnt[0]), v.cnt);
    chk({nm, " a_ld_pulses"}, nald, v.ald);
    chk({nm, " s_ld_pulses"}, nsld, v.sld);
    chk({nm, " stop_done_cycle"}, dc1, v.done1);
    chk({nm, " stop_S"}, int'(s_r[1]), v.s1);
    chk({nm, " stop_ovf_st"}, int'(ovf_st[1]), v.o_st1);
    chk({nm, " stop_cnt"}, int'(cnt[1]), v.cnt1);
    chk({nm, " stop_last_rdy"}, lr1, v.rdy1);
    @(negedge clk);
    #1;
    chk({nm, " idle_after"}, int'({busy, done}), 0);
    chk({nm, " sticky_hold"}, int'(abort_st[0]), v.a_st);
  endtask
  vec_t vecs[8];
  vec_t rv;
  initial begin
    vecs[0] = '{4'd2, ops(8'd80, 8'd80, 0, 0, 0), 0, 0, 0, 6, 'hA0, 0, 1, 0, 0, 2, 2, 6, 'hA0, 1, 0, 4};
    vecs[1] = '{4'd2, ops(8'hCE, 8'hCE, 0, 0, 0), 0, 0, 0, 6, 'h9C, 1, 0, 0, 0, 2, 2, 6, 'h9C, 0, 0, 4};
    vecs[2] = '{4'd3, ops(8'd1, 8'd1, 8'd1, 0, 0), 64'h30, 0, 0, 10, 3, 0, 0, 0, 0, 3, 3, 10, 3, 0, 0, 8};
    vecs[3] = '{4'd3, ops(8'd100, 8'd100, 8'd5, 0, 0), 0, 0, 0, 8, 'hCD, 0, 1, 0, 0, 3, 3, 6, 'hC8, 1, 1, 4};
    vecs[4] = '{4'd4, ops(8'd1, 8'd2, 8'd3, 8'd4, 0), 0, 64'h10, 64'h8, 5, 1, 0, 0, 1, 3, 1, 1, 5, 1, 0, 3, 2};
    vecs[5] = '{4'd2, ops(8'd9, 8'd9, 0, 0, 0), 0, 64'h2, 0, 2, 0, 0, 0, 1, 2, 0, 0, 2, 0, 0, 2, 0};
    vecs[6] = '{4'd0, ops(8'd7, 0, 0, 0, 0), 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0};
    vecs[7] = '{4'd15, ops(8'd1, 8'd1, 8'd1, 8'd1, 8'd1), 0, 0, 0, 32, 15, 0, 0, 0, 0, 15, 15, 32, 15, 0, 0, 30};
    #12;
    chk_zero("reset_dut0", 0);
    chk_zero("reset_dut1", 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
    start = 1'b1; len = 4'd2; vld = 1'b1; data = 8'd10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_add_s_ld", int'(s_ld[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk_zero("async_reset_dut0", 0);
    chk_zero("async_reset_dut1", 1);
    @(negedge clk);
    rst_n = 1'b1;
    vld = 1'b0;
    @(negedge clk);
    rv = '{4'd1, ops(8'd127, 0, 0, 0, 0), 0, 0, 0, 4, 'h7F, 0, 0, 0, 0, 1, 1, 4, 'h7F, 0, 0, 2};
    run_vec("post_reset", rv);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/accumulator_ctrl.md
# accumulator_ctrl

Sequencing controller for the 8-bit signed accumulator datapath. It accepts a burst command (operand count), clears the accumulator, and feeds operands from a valid/ready stream one at a time. It drives the datapath's A-load and S-load strobes in the correct order and collects the carry/overflow flags into sticky status. It sits between the operand source and the accumulator; the accumulator itself is external.

## Interface
- CNT_W, 4: width of burst length; maximum burst is 2^CNT_W-1 operands.
- STOP_ON_OVF, 0: when 1, a burst terminates early after the first ADD that reports overflow.

- i_clk  in  1  single clock, all state on rising edge
- ni_rst  in  1  asynchronous, active-low reset
- i_start  in  1  burst start request, sampled in IDLE only
- i_len  in  CNT_W  operand count, sampled with i_start
- i_abort  in  1  abort request, honored in CLR and LOAD
- i_vld  in  1  operand valid
- i_data  in  8  signed operand
- o_rdy  out  1  operand ready; transfer = i_vld & o_rdy
- o_a_data  out  8  operand to accumulator A input (= i_data, combinational)
- o_a_clr / o_s_clr  out  1 each  clear A / S register of accumulator
- o_a_ld / o_s_ld  out  1 each  load A (operand) / load S (S+A)
- i_carry / i_ovf  in  1 each  accumulator carry / signed overflow of current S+A
- o_busy  out  1  high in every state except IDLE
- o_cnt  out  CNT_W  operands remaining
- o_done  out  1  one-cycle burst-complete pulse
- o_carry_st / o_ovf_st  out  1 each  sticky carry / overflow for current burst
- o_abort_st  out  1  burst ended by i_abort

## Operation
- Datapath contract: o_a_ld loads A with o_a_data; o_s_ld performs S <= S+A; i_carry/i_ovf are valid in the cycle o_s_ld is high.
- States: IDLE, CLR, LOAD, ADD, DONE.
- IDLE: all strobes 0, o_rdy=0. If i_start=1, latch i_len into cnt, clear all sticky flags, and go to CLR.
- CLR: o_a_clr=o_s_clr=1. If i_abort=1, set o_abort_st and go to DONE. Otherwise, if cnt==0, go to DONE (result 0); else go to LOAD.
- LOAD: o_rdy=1, and o_a_ld = i_vld. If i_abort=1, it has priority: no transfer (o_rdy forced 0), set o_abort_st, go to DONE. On transfer, go to ADD; on no transfer (i_vld=0), stay in LOAD.
- ADD: o_s_ld=1. Sticky flags OR in i_carry/i_ovf, and cnt decrements. Go to DONE if the new cnt==0, or if STOP_ON_OVF=1 and i_ovf=1; else go to LOAD. i_abort is ignored in ADD; it is honored in the next LOAD.
- DONE: o_done=1 for one cycle, then go to IDLE. Sticky flags and o_cnt hold until the next i_start.
- Strobes are Moore decode of state, except o_a_ld and o_rdy, which are gated as stated above.
- i_start while o_busy=1 is ignored.
- Any async reset asserted mid-burst returns the block to IDLE immediately. The external accumulator contents are then undefined until the next CLR.

## Timing
- Reset values: state=IDLE, cnt=0, all outputs 0 (o_rdy, o_busy, o_done, all strobes, all sticky flags).
- Throughput: 2 cycles per operand (LOAD, ADD) with i_vld held high; each cycle of i_vld low adds one cycle.
- Latency, start sampled at edge 0, i_vld always high:
  - CLR in cycle 1.
  - Operand k (k = 1..N) in LOAD at cycle 2k and ADD at cycle 2k+1.
  - o_done at cycle 2N+2.
- len=0: CLR in cycle 1, o_done in cycle 2.
- Earliest next i_start is accepted in the cycle after o_done (IDLE).

## Test plan
- Reset, then len=2, operands 80, 80 → o_done at cycle 6; S=0xA0; o_ovf_st=1, o_carry_st=0, o_cnt=0.
- len=2, operands -50, -50 (0xCE, 0xCE) → S=0x9C (-100); o_carry_st=1, o_ovf_st=0.
- len=3, operands 1, 1, 1, with i_vld low for 2 cycles before the second operand → o_done at cycle 10; no flags set; exactly 3 o_a_ld and 3 o_s_ld pulses.
- STOP_ON_OVF=1, len=3, operands 100, 100, 5 → o_done at cycle 6; o_ovf_st=1, o_cnt=1; third operand never accepted (o_rdy low after cycle 5).
- len=4, i_abort pulsed in the second LOAD → no transfer that cycle; o_done next cycle; o_abort_st=1, o_cnt=3. i_start during the burst is ignored.
- ni_rst low in the middle of an ADD cycle → all outputs 0 immediately. A new len=1 burst with operand 127 → S=0x7F, no flags.
